leaf_chunk_unpacker: RTL
========================

// Module: leaf_chunk_unpacker
// PURPOSE
//  Feeds one merger-tree leaf. Dequeues 512-bit memory lines (16 x 32-bit keys) from the per-leaf
//  line buffer, serialises them LSB-word-first into the leaf's 32-bit input FIFO, and (optionally)
//  pads with terminator keys after SEQ_LEN keys. One instance per leaf, between line buffer and leaf FIFO.
// PARAMETERS
//  DATA_WIDTH      32    key width
//  WORDS_PER_LINE  16    keys per line; power of two
//  LINE_WIDTH      512   DATA_WIDTH*WORDS_PER_LINE
//  SEQ_LEN         320   keys in this leaf's sorted run
//  TERM_VALUE      0     pad key emitted after run end (TERMINATOR_EN only)
// PORTS
//  i_clk          in   1           clock
//  i_rst          in   1           asynchronous reset, active-high
//  i_line         in   LINE_WIDTH  head line of line buffer; word k = bits [32k+31:32k]
//  i_line_valid   in   1           line buffer non-empty
//  o_line_deq     out  1           combinational; line taken at this rising edge
//  o_data         out  DATA_WIDTH  registered key to leaf FIFO
//  o_write        out  1           registered enqueue strobe for o_data
//  i_fifo_full    in   1           leaf FIFO almost-full: high when <=1 free entry
//  o_word_cnt     out  32          keys of the run written so far (saturates at SEQ_LEN)
//  o_done         out  1           registered; high once o_word_cnt == SEQ_LEN
// BEHAVIOUR
//  - Reset (async, any time incl. mid-line): both line slots empty, word ptr 0, o_write 0,
//    o_data 0, o_word_cnt 0, o_done 0; o_line_deq forced 0 while i_rst high. Partial lines lost.
//  - Storage: 2 line slots (head, next) + count 0..2; ptr 0..WORDS_PER_LINE-1 into head.
//  - o_line_deq = i_line_valid & (count < 2) & ~drain. Deq'd line lands in first free slot at that edge.
//  - Emit: at an edge with count >= 1, ~i_fifo_full, ~drain: o_write<=1, o_data<=head[ptr], ptr++,
//    o_word_cnt++ (sat). Otherwise o_write<=0, o_data holds.
//  - ptr == WORDS_PER_LINE-1 on emit: ptr wraps to 0, head popped, next shifts to head.
//    Pop + deq same edge: count unchanged, new line goes to next (or head if count was 1).
//  - Latency: line deq'd at edge N -> first key has o_write high in cycle after edge N+1.
//    Sustained 1 key/cycle with no bubble across line boundaries while i_line_valid.
//  - i_fifo_full is sampled at the edge; o_write already high that cycle still enqueues (1-slot slack).
//  - o_done rises the edge o_word_cnt reaches SEQ_LEN; sticky until reset.
// CONFIGURATION
//  Macro LEAF_TERMINATOR_EN.
//   Defined: drain = o_done. After SEQ_LEN keys, slots flushed (partial trailing line discarded),
//    no further deq; o_write<=1 with o_data<=TERM_VALUE on every edge with ~i_fifo_full, indefinitely.
//   Undefined: drain = 0; block keeps unpacking lines past SEQ_LEN; o_done/o_word_cnt informational.
// STRUCTURE
//  Shared package merger_pkg: DATA_WIDTH, WORDS_PER_LINE, LINE_WIDTH, TERM_VALUE, key_t, line_t.
//  Sub-module line_slot2: 2-entry line register (head/next, count, push/pop, flush).
//  Top: ptr counter, emit logic, run counter, terminator control.
// TESTING
//  1 Line words 0x00..0x0F, fifo never full -> o_write 16 consecutive cycles, o_data 0x00..0x0F in order.
//  2 3 back-to-back lines valid -> 48 writes with no gap; o_line_deq pulses exactly 3 times.
//  3 i_fifo_full high cycles 5-9 of a line -> writes pause; no key lost or duplicated; order intact.
//  4 i_rst pulsed mid-line (ptr=7) -> o_write 0 immediately; outputs 0; next line restarts at word 0.
//  5 SEQ_LEN=40, LEAF_TERMINATOR_EN on, 3 lines fed -> 40 keys, o_done high, then only 0x00000000;
//    macro off -> 48 keys passed, o_word_cnt stuck at 40.
//  6 Pop + deq same edge with count=2 -> count stays 2, next-line ordering preserved.

Source files
------------

// File: rtl/merger_pkg.sv
// Shared merger-tree types: key and memory-line widths, terminator key.
// Line words are little-endian: word k occupies bits [32k+31:32k].
package merger_pkg;

    localparam int DATA_WIDTH     = 32;
    localparam int WORDS_PER_LINE = 16;
    localparam int LINE_WIDTH     = DATA_WIDTH * WORDS_PER_LINE;
    localparam int PTR_W          = $clog2(WORDS_PER_LINE);

    typedef logic [DATA_WIDTH-1:0] key_t;
    typedef logic [LINE_WIDTH-1:0] line_t;

    localparam key_t TERM_VALUE = '0;

    function automatic key_t line_word(line_t l, logic [PTR_W-1:0] idx);
        return l[int'(idx)*DATA_WIDTH +: DATA_WIDTH];
    endfunction

endpackage

// File: rtl/line_slot2.sv
// Two-entry line register (head/next) with push, pop and flush.
// A push alongside a pop lands in whichever slot is free after the pop.
module line_slot2
    import merger_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  logic       flush,
    input  line_t      din,
    output line_t      head,
    output logic [1:0] count
);

    line_t next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            next  <= '0;
            count <= 2'd0;
        end else if (flush) begin
            count <= 2'd0;
        end else if (push && pop) begin
            if (count == 2'd2) begin
                head <= next;
                next <= din;
            end else begin
                head <= din;
            end
        end else if (pop) begin
            head  <= next;
            count <= count - 2'd1;
        end else if (push) begin
            if (count == 2'd0) begin
                head <= din;
            end else begin
                next <= din;
            end
            count <= count + 2'd1;
        end
    end

endmodule

// File: rtl/leaf_chunk_unpacker.sv
// Serialises 512-bit lines into a leaf FIFO, LSB word first.
// LEAF_TERMINATOR_EN: after SEQ_LEN keys, flush and emit TERM_VALUE forever.
module leaf_chunk_unpacker
    import merger_pkg::*;
#(
    parameter int SEQ_LEN = 320
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  line_t       i_line,
    input  logic        i_line_valid,
    output logic        o_line_deq,
    output key_t        o_data,
    output logic        o_write,
    input  logic        i_fifo_full,
    output logic [31:0] o_word_cnt,
    output logic        o_done
);

    localparam logic [31:0] SEQ_W = 32'(SEQ_LEN);

    logic [PTR_W-1:0] ptr;
    line_t            head;
    logic [1:0]       count;
    logic             drain;
    logic             emit;
    logic             last;
    logic             pop;

`ifdef LEAF_TERMINATOR_EN
    assign drain = o_done;
`else
    assign drain = 1'b0;
`endif

    assign emit = (count != 2'd0) & ~i_fifo_full & ~drain;
    assign last = (ptr == PTR_W'(WORDS_PER_LINE - 1));
    assign pop  = emit & last;

    assign o_line_deq = ~i_rst & i_line_valid
                      & (count < 2'd2) & ~drain;

    line_slot2 u_slots (
        .clk   (i_clk),
        .rst   (i_rst),
        .push  (o_line_deq),
        .pop   (pop),
        .flush (drain),
        .din   (i_line),
        .head  (head),
        .count (count)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ptr        <= '0;
            o_write    <= 1'b0;
            o_data     <= '0;
            o_word_cnt <= '0;
            o_done     <= 1'b0;
        end else begin
            o_write <= 1'b0;
            if (emit) begin
                o_write <= 1'b1;
                o_data  <= line_word(head, ptr);
                ptr     <= last ? '0 : ptr + PTR_W'(1);
                if (o_word_cnt != SEQ_W) begin
                    o_word_cnt <= o_word_cnt + 32'd1;
                end
                if (o_word_cnt == SEQ_W - 32'd1) begin
                    o_done <= 1'b1;
                end
            end
`ifdef LEAF_TERMINATOR_EN
            else if (drain) begin
                ptr <= '0;
                if (!i_fifo_full) begin
                    o_write <= 1'b1;
                    o_data  <= TERM_VALUE;
                end
            end
`endif
        end
    end

endmodule
